// File: rtl/fetch_issue_pkg.sv
// Shared encodings for the fetch-to-decode issue controller: states, flag bit
// indices, the idle-slot instruction and a small helper.
package fetch_issue_pkg;

  localparam logic FIC_S_PKT  = 1'b0;
  localparam logic FIC_S_HALF = 1'b1;

  typedef enum logic {
    S_PKT  = FIC_S_PKT,
    S_HALF = FIC_S_HALF
  } fic_state_e;

  // bit k of priv/branch flags refers to instruction k of the packet
  localparam int FIC_INST0 = 0;
  localparam int FIC_INST1 = 1;

  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_issue_ctrl_perf.sv
// Issue statistics counters: dual-issue cycles, single-issue cycles and
// cycles where decode had room but the fetch FIFO was empty.
module fetch_issue_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        pair_inc,
  input  logic        single_inc,
  input  logic        starve_inc,
  output logic [31:0] perf_pair_cnt,
  output logic [31:0] perf_single_cnt,
  output logic [31:0] perf_starve_cnt
);

  logic [31:0] pair_q, pair_d;
  logic [31:0] single_q, single_d;
  logic [31:0] starve_q, starve_d;

  always_comb begin
    pair_d   = pair_q   + {31'd0, pair_inc};
    single_d = single_q + {31'd0, single_inc};
    starve_d = starve_q + {31'd0, starve_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q   <= '0;
      single_q <= '0;
      starve_q <= '0;
    end else begin
      pair_q   <= pair_d;
      single_q <= single_d;
      starve_q <= starve_d;
    end
  end

  assign perf_pair_cnt   = pair_q;
  assign perf_single_cnt = single_q;
  assign perf_starve_cnt = starve_q;

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Splits fetch FIFO packets (up to two instructions) across decode slots 0/1
// and pops the FIFO once a packet is fully issued. FETCH_ISSUE_PERF_EN adds counters.
module fetch_issue_ctrl
  import fetch_issue_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_valid,
  input  logic [INST_W-1:0] fifo_inst0,
  input  logic [INST_W-1:0] fifo_inst1,
  input  logic [PC_W-1:0]   fifo_pc,
  input  logic [PC_W-1:0]   fifo_pc_next,
  input  logic              fifo_pc_taken,
  input  logic [6:0]        fifo_exception,
  input  logic [1:0]        fifo_excp_flag,
  input  logic [1:0]        fifo_priv_flag,
  input  logic [1:0]        fifo_branch_flag,
  output logic              fifo_ready,
  input  logic [1:0]        id_slots,
  output logic              s0_valid,
  output logic              s1_valid,
  output logic [INST_W-1:0] s0_inst,
  output logic [INST_W-1:0] s1_inst,
  output logic [PC_W-1:0]   s0_pc,
  output logic [PC_W-1:0]   s1_pc,
  output logic              s0_priv,
  output logic              s1_priv,
  output logic [1:0]        s0_excp_flag,
  output logic [6:0]        s0_exception,
  output logic              s0_pred_taken,
  output logic              s1_pred_taken,
  output logic [PC_W-1:0]   s0_pred_tgt,
  output logic [PC_W-1:0]   s1_pred_tgt,
  output logic [31:0]       perf_pair_cnt,
  output logic [31:0]       perf_single_cnt,
  output logic [31:0]       perf_starve_cnt
);

  fic_state_e state_q, state_d;

  logic [PC_W-1:0] pc_plus4;
  logic [1:0]      slots, n, k;
  logic            has1, pair;

  assign pc_plus4 = fifo_pc + PC_W'(4);
  assign slots    = (id_slots == 2'd3) ? 2'd2 : id_slots;
  // inst1 exists only when inst0 is the even word and nothing cuts the packet short
  assign has1     = !fifo_pc[2] && (fifo_excp_flag == 2'b00) && !fifo_branch_flag[FIC_INST0];
  assign pair     = has1 && (fifo_priv_flag == 2'b00);

  always_comb begin
    n = 2'd0;
    if (fifo_valid) n = (state_q == S_PKT && pair) ? 2'd2 : 2'd1;
    k = (rst || flush) ? 2'd0 : min2(n, slots);
  end

  always_comb begin
    s0_valid      = (k != 2'd0);
    s1_valid      = (k == 2'd2);
    s1_inst       = fifo_inst1;
    s1_pc         = pc_plus4;
    s1_priv       = fifo_priv_flag[FIC_INST1];
    s1_pred_taken = fifo_pc_taken;
    s1_pred_tgt   = fifo_pc_next;
    if (state_q == S_PKT) begin
      s0_inst       = fifo_inst0;
      s0_pc         = fifo_pc;
      s0_priv       = fifo_priv_flag[FIC_INST0];
      s0_excp_flag  = fifo_excp_flag;
      s0_exception  = fifo_exception;
      s0_pred_taken = has1 ? 1'b0 : fifo_pc_taken;
      s0_pred_tgt   = has1 ? pc_plus4 : fifo_pc_next;
    end else begin
      s0_inst       = fifo_inst1;
      s0_pc         = pc_plus4;
      s0_priv       = fifo_priv_flag[FIC_INST1];
      s0_excp_flag  = 2'b00;
      s0_exception  = 7'd0;
      s0_pred_taken = fifo_pc_taken;
      s0_pred_tgt   = fifo_pc_next;
    end
    if (!s0_valid) s0_inst = INST_NOP;
    if (!s1_valid) s1_inst = INST_NOP;
  end

  always_comb begin
    state_d    = state_q;
    fifo_ready = 1'b0;
    if (flush) begin
      state_d = S_PKT;
    end else if (state_q == S_PKT) begin
      if (k == 2'd1 && has1)        state_d    = S_HALF;
      else if (k != 2'd0 && k == n) fifo_ready = 1'b1;
    end else if (k == 2'd1) begin
      fifo_ready = 1'b1;
      state_d    = S_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_PKT;
    else     state_q <= state_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_HALF && !flush)
      assert (fifo_valid) else $error("fetch_issue_ctrl: fifo_valid dropped with inst1 pending");
  end
`endif

`ifdef FETCH_ISSUE_PERF_EN
  fetch_issue_perf u_perf (
    .clk             (clk),
    .rst             (rst),
    .pair_inc        (k == 2'd2),
    .single_inc      (k == 2'd1),
    .starve_inc      (id_slots != 2'd0 && !fifo_valid && !flush),
    .perf_pair_cnt   (perf_pair_cnt),
    .perf_single_cnt (perf_single_cnt),
    .perf_starve_cnt (perf_starve_cnt)
  );
`else
  assign perf_pair_cnt   = 32'd0;
  assign perf_single_cnt = 32'd0;
  assign perf_starve_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl: inputs change on negedge, outputs are
// checked 1ns later, each @(negedge clk) advances one clock.
module tb_fetch_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, fifo_valid, fifo_pc_taken, fifo_ready;
  logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next;
  logic [6:0]  fifo_exception;
  logic [1:0]  fifo_excp_flag, fifo_priv_flag, fifo_branch_flag, id_slots;
  logic        s0_valid, s1_valid, s0_priv, s1_priv, s0_pred_taken, s1_pred_taken;
  logic [31:0] s0_inst, s1_inst, s0_pc, s1_pc, s0_pred_tgt, s1_pred_tgt;
  logic [1:0]  s0_excp_flag;
  logic [6:0]  s0_exception;
  logic [31:0] perf_pair_cnt, perf_single_cnt, perf_starve_cnt;

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] IA  = 32'h0280_0421;
  localparam logic [31:0] IB  = 32'h0280_0842;
  localparam logic [31:0] PC0 = 32'h1c00_0000;
  localparam logic [31:0] TGT = 32'h1c00_0100;

  always #5 clk = ~clk;

  fetch_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_valid(fifo_valid),
    .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1), .fifo_pc(fifo_pc),
    .fifo_pc_next(fifo_pc_next), .fifo_pc_taken(fifo_pc_taken),
    .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag),
    .fifo_priv_flag(fifo_priv_flag), .fifo_branch_flag(fifo_branch_flag),
    .fifo_ready(fifo_ready), .id_slots(id_slots),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_inst(s0_inst), .s1_inst(s1_inst),
    .s0_pc(s0_pc), .s1_pc(s1_pc), .s0_priv(s0_priv), .s1_priv(s1_priv),
    .s0_excp_flag(s0_excp_flag), .s0_exception(s0_exception),
    .s0_pred_taken(s0_pred_taken), .s1_pred_taken(s1_pred_taken),
    .s0_pred_tgt(s0_pred_tgt), .s1_pred_tgt(s1_pred_tgt),
    .perf_pair_cnt(perf_pair_cnt), .perf_single_cnt(perf_single_cnt),
    .perf_starve_cnt(perf_starve_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pkt(input logic [31:0] pc, input logic [1:0] priv, input logic [1:0] excp,
                     input logic [6:0] code, input logic [1:0] slots);
    fifo_valid = 1'b1; fifo_inst0 = IA; fifo_inst1 = IB; fifo_pc = pc;
    fifo_pc_next = TGT; fifo_pc_taken = 1'b1; fifo_exception = code;
    fifo_excp_flag = excp; fifo_priv_flag = priv; fifo_branch_flag = 2'b00;
    id_slots = slots;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    pkt(PC0, 2'b00, 2'b00, 7'd0, 2'd2);
    #1;
    chk("rst_s0_valid", {31'd0, s0_valid}, 32'd0);
    chk("rst_s1_valid", {31'd0, s1_valid}, 32'd0);
    chk("rst_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pair_cnt", perf_pair_cnt, 32'd0);
    chk("rst_starve_cnt", perf_starve_cnt, 32'd0);

    // 1: full pair issue, packet-end prediction rides on slot1
    chk("t1_s0_valid", {31'd0, s0_valid}, 32'd1);
    chk("t1_s1_valid", {31'd0, s1_valid}, 32'd1);
    chk("t1_s0_pc", s0_pc, PC0);
    chk("t1_s1_pc", s1_pc, PC0 + 32'd4);
    chk("t1_s1_inst", s1_inst, IB);
    chk("t1_ready", {31'd0, fifo_ready}, 32'd1);
    chk("t1_s0_pred_taken", {31'd0, s0_pred_taken}, 32'd0);
    chk("t1_s0_pred_tgt", s0_pred_tgt, PC0 + 32'd4);
    chk("t1_s1_pred_taken", {31'd0, s1_pred_taken}, 32'd1);
    chk("t1_s1_pred_tgt", s1_pred_tgt, TGT);
    @(negedge clk);

    // 2: same packet, one slot: split across two cycles
    pkt(PC0, 2'b00, 2'b00, 7'd0, 2'd1);
    #1;
    chk("t2a_s0_inst", s0_inst, IA);
    chk("t2a_s1_valid", {31'd0, s1_valid}, 32'd0);
    chk("t2a_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge clk); #1;
    chk("t2b_s0_valid", {31'd0, s0_valid}, 32'd1);
    chk("t2b_s0_inst", s0_inst, IB);
    chk("t2b_s0_pc", s0_pc, PC0 + 32'd4);
    chk("t2b_s0_pred_taken", {31'd0, s0_pred_taken}, 32'd1);
    chk("t2b_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge clk);
`ifdef FETCH_ISSUE_PERF_EN
    #1;
    chk("t2_pair_cnt", perf_pair_cnt, 32'd1);
    chk("t2_single_cnt", perf_single_cnt, 32'd2);
`endif

    // 3: serializing inst0 blocks dual issue even with two slots
    pkt(PC0, 2'b01, 2'b00, 7'd0, 2'd2);
    #1;
    chk("t3a_s0_priv", {31'd0, s0_priv}, 32'd1);
    chk("t3a_s1_valid", {31'd0, s1_valid}, 32'd0);
    chk("t3a_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge clk); #1;
    chk("t3b_s0_inst", s0_inst, IB);
    chk("t3b_s0_priv", {31'd0, s0_priv}, 32'd0);
    chk("t3b_s1_valid", {31'd0, s1_valid}, 32'd0);
    chk("t3b_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge clk);

    // 4: odd-word packet has only inst0, which is the packet end
    pkt(PC0 + 32'd4, 2'b00, 2'b00, 7'd0, 2'd2);
    #1;
    chk("t4_s0_valid", {31'd0, s0_valid}, 32'd1);
    chk("t4_s1_valid", {31'd0, s1_valid}, 32'd0);
    chk("t4_s0_pred_tgt", s0_pred_tgt, TGT);
    chk("t4_s0_pred_taken", {31'd0, s0_pred_taken}, 32'd1);
    chk("t4_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge clk);

    // 5: fetch exception truncates the packet to inst0
    pkt(PC0, 2'b00, 2'b01, 7'h08, 2'd2);
    #1;
    chk("t5_excp_flag", {30'd0, s0_excp_flag}, 32'd1);
    chk("t5_exception", {25'd0, s0_exception}, 32'h08);
    chk("t5_s1_valid", {31'd0, s1_valid}, 32'd0);
    chk("t5_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge clk);

    // no decode room: nothing issues, nothing pops
    pkt(PC0, 2'b00, 2'b00, 7'd0, 2'd0);
    #1;
    chk("z_s0_valid", {31'd0, s0_valid}, 32'd0);
    chk("z_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge clk);

    // id_slots=3 behaves as 2
    pkt(PC0, 2'b00, 2'b00, 7'd0, 2'd3);
    #1;
    chk("s3_s1_valid", {31'd0, s1_valid}, 32'd1);
    chk("s3_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge clk);

    // empty FIFO: no pop, counts one starve cycle
    fifo_valid = 1'b0; id_slots = 2'd2;
    #1;
    chk("e_s0_valid", {31'd0, s0_valid}, 32'd0);
    chk("e_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge clk);

    // 6: flush while inst1 pending returns to a fresh packet
    pkt(PC0, 2'b00, 2'b00, 7'd0, 2'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("t6_flush_s0_valid", {31'd0, s0_valid}, 32'd0);
    chk("t6_flush_ready", {31'd0, fifo_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; id_slots = 2'd2;
    #1;
    chk("t6_s0_inst", s0_inst, IA);
    chk("t6_s0_pc", s0_pc, PC0);
    chk("t6_s1_valid", {31'd0, s1_valid}, 32'd1);
    chk("t6_ready", {31'd0, fifo_ready}, 32'd1);
    @(negedge clk);
    fifo_valid = 1'b0; id_slots = 2'd0;
    #1;

`ifdef FETCH_ISSUE_PERF_EN
    chk("end_pair_cnt", perf_pair_cnt, 32'd3);
    chk("end_single_cnt", perf_single_cnt, 32'd7);
    chk("end_starve_cnt", perf_starve_cnt, 32'd1);
`else
    chk("end_pair_cnt", perf_pair_cnt, 32'd0);
    chk("end_single_cnt", perf_single_cnt, 32'd0);
    chk("end_starve_cnt", perf_starve_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
